// File: rtl/sn_uart_rx_cfg_if.sv
// rtl/sn_uart_rx_cfg_if.sv - show-ahead read port of the UART receive FIFO
interface sn_uart_rx_cfg_if #(
    parameter int P_DATA_BITS = 8
);
    logic                   rd_en;
    logic [P_DATA_BITS-1:0] rd_data;
    logic                   rd_valid;
    logic                   rd_parity_err;
    logic                   rd_frame_err;
    logic                   fifo_full;

    // receiver side: presents the head word, accepts pops
    modport master (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output rd_parity_err,
        output rd_frame_err,
        output fifo_full
    );

    // consumer side: reads the head word, requests pops
    modport slave (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  rd_parity_err,
        input  rd_frame_err,
        input  fifo_full
    );
endinterface

// File: rtl/sn_uart_rx_cfg.sv
// rtl/sn_uart_rx_cfg.sv - configurable UART receiver with majority voting and receive FIFO
module sn_uart_rx_cfg #(
    parameter int P_CLKS_PER_BIT = 54,
    parameter int P_DATA_BITS    = 8,
    parameter int P_PARITY       = 0,
    parameter int P_STOP_BITS    = 1,
    parameter int P_FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx_enable,
    input  logic             i_rx_input,
    input  logic             i_clr_errors,
    sn_uart_rx_cfg_if.master rd_if,
    output logic             o_overrun,
    output logic             o_rx_done,
    output logic             o_rx_active
);
    localparam int LP_Q  = P_CLKS_PER_BIT / 4;
    localparam int LP_CW = $clog2(P_CLKS_PER_BIT);
    localparam int LP_AW = $clog2(P_FIFO_DEPTH);
    localparam int LP_NW = LP_AW + 1;
    localparam int LP_WW = P_DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [LP_CW-1:0]       r_clk_count;
    logic [3:0]             r_bit_idx;
    logic                   r_s1;
    logic                   r_s2;
    logic                   r_bit_val;
    logic [P_DATA_BITS-1:0] r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_rx_done;
    logic                   r_rx_active;
    logic                   r_overrun;

    logic [LP_WW-1:0]       r_mem [P_FIFO_DEPTH];
    logic [LP_AW-1:0]       r_wr_ptr;
    logic [LP_AW-1:0]       r_rd_ptr;
    logic [LP_NW-1:0]       r_count;

    logic                   w_rxs;
    logic                   w_at_q1;
    logic                   w_at_q2;
    logic                   w_at_q3;
    logic                   w_at_end;
    logic                   w_maj;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_store;
    logic                   w_drop;
    logic [LP_WW-1:0]       w_push_word;
    logic [LP_WW-1:0]       w_head;

    assign w_rxs    = r_sync2;
    assign w_at_q1  = (r_clk_count == LP_CW'(LP_Q));
    assign w_at_q2  = (r_clk_count == LP_CW'(2 * LP_Q));
    assign w_at_q3  = (r_clk_count == LP_CW'(3 * LP_Q));
    assign w_at_end = (r_clk_count == LP_CW'(P_CLKS_PER_BIT - 1));
    // third sample is taken live at 3Q, the first two were latched earlier
    assign w_maj    = (r_s1 & r_s2) | (r_s1 & w_rxs) | (r_s2 & w_rxs);

    // frame ends at 3Q of the last stop bit so back-to-back frames can slip
    assign w_push      = (r_state == S_STOP) && (r_bit_idx == 4'(P_STOP_BITS - 1)) && w_at_q3;
    assign w_push_word = {r_ferr | ~w_maj, r_perr, r_shift};
    assign w_full      = (r_count == LP_NW'(P_FIFO_DEPTH));
    assign w_pop       = rd_if.rd_en && (r_count != '0);
    assign w_store     = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_head      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    // two-flop synchroniser, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_input;
            r_sync2 <= r_sync1;
        end
    end

    // frame receiver: bit timing, majority sampling, shift and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clk_count <= '0;
            r_bit_idx   <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_bit_val   <= 1'b0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_active <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_count <= '0;
                    r_bit_idx   <= '0;
                    if (i_rx_enable) begin
                        r_state     <= S_WAIT_START;
                        r_rx_active <= 1'b1;
                    end
                end
                S_WAIT_START: begin
                    r_clk_count <= '0;
                    r_bit_idx   <= '0;
                    if (!i_rx_enable) begin
                        r_state     <= S_IDLE;
                        r_rx_active <= 1'b0;
                    end else if (!w_rxs) begin
                        r_state <= S_START;
                    end
                end
                default: begin
                    if (w_at_q1) r_s1 <= w_rxs;
                    if (w_at_q2) r_s2 <= w_rxs;
                    if (w_at_q3) r_bit_val <= w_maj;
                    r_clk_count <= w_at_end ? '0 : r_clk_count + 1'b1;
                    case (r_state)
                        S_START: begin
                            if (w_at_end) begin
                                // a start bit that votes high was noise; keep listening
                                if (!r_bit_val) begin
                                    r_state   <= S_DATA;
                                    r_bit_idx <= '0;
                                    r_perr    <= 1'b0;
                                    r_ferr    <= 1'b0;
                                end else begin
                                    r_state <= S_WAIT_START;
                                end
                            end
                        end
                        S_DATA: begin
                            if (w_at_end) begin
                                r_shift <= {r_bit_val, r_shift[P_DATA_BITS-1:1]};
                                if (r_bit_idx == 4'(P_DATA_BITS - 1)) begin
                                    r_bit_idx <= '0;
                                    r_state   <= (P_PARITY != 0) ? S_PARITY : S_STOP;
                                end else begin
                                    r_bit_idx <= r_bit_idx + 1'b1;
                                end
                            end
                        end
                        S_PARITY: begin
                            if (w_at_end) begin
                                r_perr <= ((^r_shift) ^ r_bit_val) != (P_PARITY == 1);
                                r_state <= S_STOP;
                            end
                        end
                        S_STOP: begin
                            if (w_push) begin
                                r_rx_done   <= 1'b1;
                                r_clk_count <= '0;
                                r_bit_idx   <= '0;
                                r_state     <= i_rx_enable ? S_WAIT_START : S_IDLE;
                                r_rx_active <= i_rx_enable;
                            end else if (w_at_end) begin
                                r_ferr    <= r_ferr | ~r_bit_val;
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end
                        default: begin
                            r_state     <= S_IDLE;
                            r_rx_active <= 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the head
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr] <= w_push_word;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + LP_NW'(w_store) - LP_NW'(w_pop);
        end
    end

    // sticky overrun; a new drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_errors) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_if.rd_data       = w_head[P_DATA_BITS-1:0];
    assign rd_if.rd_parity_err = w_head[P_DATA_BITS];
    assign rd_if.rd_frame_err  = w_head[P_DATA_BITS+1];
    assign rd_if.rd_valid      = (r_count != '0);
    assign rd_if.fifo_full     = w_full;
    assign o_overrun           = r_overrun;
    assign o_rx_done           = r_rx_done;
    assign o_rx_active         = r_rx_active;
endmodule

// File: tb/tb_sn_uart_rx_cfg.sv
// tb/tb_sn_uart_rx_cfg.sv - directed and randomized checks of sn_uart_rx_cfg
module tb_sn_uart_rx_cfg;
    localparam int CPB = 54;
    localparam int Q   = CPB / 4;

    logic clk = 1'b0;
    logic rst;
    logic rx_en_a, rx_a, clr_a, ovr_a, done_a, act_a;
    logic rx_en_b, rx_b, clr_b, ovr_b, done_b, act_b;

    sn_uart_rx_cfg_if #(.P_DATA_BITS(8)) ifa ();
    sn_uart_rx_cfg_if #(.P_DATA_BITS(7)) ifb ();

    sn_uart_rx_cfg u_a (
        .clk(clk), .rst(rst), .i_rx_enable(rx_en_a), .i_rx_input(rx_a), .i_clr_errors(clr_a),
        .rd_if(ifa), .o_overrun(ovr_a), .o_rx_done(done_a), .o_rx_active(act_a)
    );

    sn_uart_rx_cfg #(.P_DATA_BITS(7), .P_PARITY(2), .P_STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .i_rx_enable(rx_en_b), .i_rx_input(rx_b), .i_clr_errors(clr_b),
        .rd_if(ifb), .o_overrun(ovr_b), .o_rx_done(done_b), .o_rx_active(act_b)
    );

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    done_cnt_a = 0;
    int    done_cnt_b = 0;
    int    last_done_a = 0;
    int    last_done_b = 0;
    logic  valid_at_done_a = 1'b0;
    int    t_start = 0;
    word_t model_q[$];
    logic  model_ovr;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            done_cnt_a++;
            last_done_a = cyc;
            valid_at_done_a = ifa.rd_valid;
        end
        if (done_b === 1'b1) begin
            done_cnt_b++;
            last_done_b = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // clocks from the bench driving the start bit to rx_done: 3 for synchroniser/detect, then N*CPB+3Q+1
    function automatic int lat(input int nbits, input int par, input int nstop);
        int n;
        n = nbits + ((par != 0) ? 1 : 0) + nstop;
        return 3 + n * CPB + 3 * Q + 1;
    endfunction

    task automatic drive_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits, input int par,
                              input int nstop, input bit bad_par, input bit bad_stop,
                              input int gbit, input int goff, input int pop_at);
        logic bits[$];
        logic p;
        int   k;
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (par == 1) p = ~p;
        if (par != 0) bits.push_back(p ^ bad_par);
        for (int i = 0; i < nstop; i++) bits.push_back(!(bad_stop && (i == nstop - 1)));
        k = 0;
        foreach (bits[b]) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk); #1;
                if (k == 0) t_start = cyc;
                drive_line(sel, bits[b] ^ ((b == gbit) && (c == goff)));
                if (sel == 0) ifa.rd_en = (k == pop_at);
                k++;
            end
        end
        @(posedge clk); #1;
        drive_line(sel, 1'b1);
        if (sel == 0) ifa.rd_en = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input int sel, input string tag, input logic [8:0] ed, input logic ep, input logic ef);
        if (sel == 0) begin
            chk(tag, 32'({ifa.rd_valid, ifa.rd_frame_err, ifa.rd_parity_err, ifa.rd_data}), 32'({1'b1, ef, ep, ed[7:0]}));
            ifa.rd_en = 1'b1;
            @(posedge clk); #1;
            ifa.rd_en = 1'b0;
        end else begin
            chk(tag, 32'({ifb.rd_valid, ifb.rd_frame_err, ifb.rd_parity_err, ifb.rd_data}), 32'({1'b1, ef, ep, ed[6:0]}));
            ifb.rd_en = 1'b1;
            @(posedge clk); #1;
            ifb.rd_en = 1'b0;
        end
    endtask

    initial begin
        int    d;
        int    npop;
        word_t w;
        bit    bp;

        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1;
        rx_en_a = 1'b0; rx_en_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        ifa.rd_en = 1'b0; ifb.rd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset a", 32'({ifa.rd_valid, ifa.rd_data, ifa.rd_parity_err, ifa.rd_frame_err, ifa.fifo_full, ovr_a, done_a, act_a}), 32'd0);
        chk("reset b", 32'({ifb.rd_valid, ifb.rd_data, ifb.fifo_full, ovr_b, done_b, act_b}), 32'd0);
        rst = 1'b0;
        rx_en_a = 1'b1; rx_en_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("active after enable", 32'({act_a, act_b}), 32'd3);

        d = done_cnt_a;
        send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, 1'b0, -1, 0, -1);
        chk("a5 done count", 32'(done_cnt_a - d), 32'd1);
        chk("a5 latency", 32'(last_done_a - t_start), 32'(lat(8, 0, 1)));
        chk("a5 valid with done", 32'(valid_at_done_a), 32'd1);
        pop_check(0, "a5 word", 9'h0A5, 1'b0, 1'b0);
        chk("a5 empty after pop", 32'(ifa.rd_valid), 32'd0);

        d = done_cnt_a;
        @(posedge clk); #1;
        rx_a = 1'b0;
        repeat (Q) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("glitch no done", 32'(done_cnt_a - d), 32'd0);
        chk("glitch no entry", 32'(ifa.rd_valid), 32'd0);
        chk("glitch still listening", 32'(act_a), 32'd1);
        send_frame(0, 9'h03C, 8, 0, 1, 1'b0, 1'b0, -1, 0, -1);
        chk("3c done count", 32'(done_cnt_a - d), 32'd1);
        pop_check(0, "3c word", 9'h03C, 1'b0, 1'b0);

        send_frame(0, 9'h000, 8, 0, 1, 1'b0, 1'b0, 4, 2 * Q + 1, -1);
        pop_check(0, "vote word", 9'h000, 1'b0, 1'b0);

        send_frame(0, 9'h07E, 8, 0, 1, 1'b0, 1'b1, -1, 0, -1);
        pop_check(0, "stop low word", 9'h07E, 1'b0, 1'b1);

        send_frame(0, 9'h05A, 8, 0, 1, 1'b0, 1'b0, -1, 0, lat(8, 0, 1) - 1);
        chk("push pop empty valid", 32'(ifa.rd_valid), 32'd1);
        pop_check(0, "push pop empty word", 9'h05A, 1'b0, 1'b0);

        d = done_cnt_a;
        for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 8, 0, 1, 1'b0, 1'b0, -1, 0, -1);
        chk("ovf done count", 32'(done_cnt_a - d), 32'd5);
        chk("ovf full", 32'(ifa.fifo_full), 32'd1);
        chk("ovf overrun", 32'(ovr_a), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check(0, "ovf pop", 9'(i), 1'b0, 1'b0);
        chk("ovf drained", 32'(ifa.rd_valid), 32'd0);
        chk("ovf overrun sticky", 32'(ovr_a), 32'd1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("overrun cleared", 32'(ovr_a), 32'd0);

        d = done_cnt_a;
        for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 8, 0, 1, 1'b0, 1'b0, -1, 0, -1);
        send_frame(0, 9'h005, 8, 0, 1, 1'b0, 1'b0, -1, 0, lat(8, 0, 1) - 1);
        chk("full pushpop done count", 32'(done_cnt_a - d), 32'd5);
        chk("full pushpop full", 32'(ifa.fifo_full), 32'd1);
        chk("full pushpop no overrun", 32'(ovr_a), 32'd0);
        for (int i = 2; i <= 5; i++) pop_check(0, "full pushpop pop", 9'(i), 1'b0, 1'b0);

        d = done_cnt_b;
        send_frame(1, 9'h041, 7, 2, 2, 1'b1, 1'b0, -1, 0, -1);
        chk("b latency", 32'(last_done_b - t_start), 32'(lat(7, 2, 2)));
        send_frame(1, 9'h041, 7, 2, 2, 1'b0, 1'b0, -1, 0, -1);
        chk("b done count", 32'(done_cnt_b - d), 32'd2);
        pop_check(1, "b bad parity word", 9'h041, 1'b1, 1'b0);
        pop_check(1, "b good parity word", 9'h041, 1'b0, 1'b0);

        model_q.delete();
        model_ovr = 1'b0;
        for (int n = 0; n < 14; n++) begin
            npop = $urandom_range(0, 2);
            for (int j = 0; j < npop; j++) begin
                if (model_q.size() > 0) begin
                    w = model_q.pop_front();
                    pop_check(0, "rand a pop", w.data, w.perr, w.ferr);
                end
            end
            w.data = 9'($urandom_range(0, 255));
            w.perr = 1'b0;
            w.ferr = ($urandom_range(0, 5) == 0);
            d = done_cnt_a;
            send_frame(0, w.data, 8, 0, 1, 1'b0, w.ferr, -1, 0, -1);
            if (model_q.size() < 4) model_q.push_back(w);
            else model_ovr = 1'b1;
            chk("rand a done count", 32'(done_cnt_a - d), 32'd1);
            chk("rand a full", 32'(ifa.fifo_full), 32'(model_q.size() == 4));
            chk("rand a overrun", 32'(ovr_a), 32'(model_ovr));
        end
        while (model_q.size() > 0) begin
            w = model_q.pop_front();
            pop_check(0, "rand a drain", w.data, w.perr, w.ferr);
        end
        chk("rand a empty", 32'(ifa.rd_valid), 32'd0);

        for (int n = 0; n < 8; n++) begin
            w.data = 9'($urandom_range(0, 127));
            bp = ($urandom_range(0, 1) == 1);
            w.perr = bp;
            w.ferr = 1'b0;
            send_frame(1, w.data, 7, 2, 2, bp, 1'b0, -1, 0, -1);
            pop_check(1, "rand b word", w.data, w.perr, w.ferr);
        end
        chk("rand b empty", 32'(ifb.rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sn_uart_rx_cfg.md
Name: sn_uart_rx_cfg

Overview:
Parametrised UART receiver with configurable frame format and a small receive FIFO. Adds an input synchroniser and 3-sample majority voting on every bit. Flags parity, framing and overrun errors per word. Sits between the UART pin and io_controller, which drains received words through a show-ahead read interface instead of a single holding register.

Parameters:
P_CLKS_PER_BIT, 54, clk cycles per bit (clk rate / baud), minimum 8
P_DATA_BITS, 8, data bits per frame, legal range 5..9
P_PARITY, 0, 0 = none, 1 = odd, 2 = even
P_STOP_BITS, 1, stop bits per frame, 1 or 2
P_FIFO_DEPTH, 4, receive FIFO entries, power of 2, minimum 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rx_enable  in  1  high = receiver listens for frames
rx_input  in  1  asynchronous serial line, idle high
rd_en  in  1  pop request; honoured only while rd_valid is high
clr_errors  in  1  one-cycle pulse that clears overrun
rd_data  out  P_DATA_BITS  data word at FIFO head
rd_valid  out  1  FIFO not empty
rd_parity_err  out  1  parity error flag of the head word (always 0 when P_PARITY = 0)
rd_frame_err  out  1  stop-bit error flag of the head word
fifo_full  out  1  FIFO holds P_FIFO_DEPTH entries
overrun  out  1  sticky; a completed frame was dropped because the FIFO was full
rx_done  out  1  one-cycle pulse per completed frame, whether stored or dropped
rx_active  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, both synchroniser flops set to 1, state IDLE, all counters 0.
- Reset mid-frame: the frame is aborted and the FIFO is flushed. No rx_done pulse is generated.
- Synchroniser: rx_input passes through 2 flops; "rxs" below means the second flop output. Everything downstream uses only rxs.
- Sample points within each bit period, with Q = floor(P_CLKS_PER_BIT/4):
  - rxs is sampled at clk_count = Q, 2Q and 3Q.
  - The bit value is the majority of the three samples, not an OR.
  - clk_count runs 0..P_CLKS_PER_BIT-1, then wraps to 0.
- States:
  - IDLE: counters cleared. Goes to WAIT_START when rx_enable = 1.
  - WAIT_START: stays while rxs = 1. On rxs = 0, goes to START with clk_count = 0. Goes to IDLE if rx_enable = 0.
  - START: at clk_count = CPB-1, majority 0 goes to DATA. Majority 1 is a false start and returns to WAIT_START (not IDLE); no flag, no rx_done.
  - DATA: P_DATA_BITS bit periods, LSB first, shifted into a P_DATA_BITS-wide register. Then goes to PARITY if P_PARITY != 0, otherwise to STOP.
  - PARITY: one bit period. parity_err = 1 when the received bit does not match odd/even parity computed over the data bits.
  - STOP: P_STOP_BITS bit periods. frame_err = 1 if any stop-bit majority is 0.
- Frame completion:
  - The frame completes at clk_count = 3Q of the final stop bit. It does not wait for the end of the bit period, so back-to-back frames tolerate clock mismatch.
  - In that cycle the word is pushed with its two flags.
  - The next state is WAIT_START if rx_enable = 1, otherwise IDLE.
- rx_enable dropping mid-frame: the current frame still completes and is pushed; the block then goes to IDLE.
- Latency: rx_done is high exactly N·CPB + 3Q + 1 clocks after the clk edge at which WAIT_START first sees rxs = 0. N = 1 + P_DATA_BITS + (P_PARITY != 0) + P_STOP_BITS − 1.
- rd_valid and the new head word become visible in the same cycle as rx_done.
- FIFO: show-ahead. rd_data and the two flags always reflect the head entry.
  - Pop when rd_en = 1 and rd_valid = 1.
  - rd_en while empty is ignored.
- Push while full, no pop: the word is discarded, overrun is set, and rx_done still pulses.
- Push and pop in the same cycle when full: both take effect, occupancy is unchanged, and overrun is not set.
- Push and pop in the same cycle when empty: the push takes effect and the FIFO ends with 1 entry.
- overrun clearing: overrun is cleared only by clr_errors or rst. If clr_errors and a new overrun occur in the same cycle, the set wins.
- Pointers: wrap modulo P_FIFO_DEPTH. Occupancy uses a $clog2(P_FIFO_DEPTH)+1-bit count.

Test Plan:
- Defaults, CPB = 54; drive 0x A5 as 8N1 with correct stop bit → one rx_done; rd_data = 0xA5; both error flags 0; latency matches the formula exactly.
- P_PARITY = 2, P_DATA_BITS = 7; send 0x41 with wrong parity bit, then 0x41 with correct parity → entries {0x41, perr = 1} then {0x41, perr = 0}.
- Low glitch of CPB/4 cycles on an idle line → no rx_done and no FIFO entry; the state returns to WAIT_START and a following valid 0x3C frame is received correctly.
- Single-sample glitch (1 cycle) inverted at the 2Q point of data bit 3 of frame 0x00 → majority vote yields rd_data = 0x00.
- Stop bit held low on frame 0x7E → rd_frame_err = 1, rd_data = 0x7E.
- Depth 4, no reads; send 5 frames 0x01..0x05 → fifo_full = 1, overrun = 1, five rx_done pulses, pops return 0x01..0x04. Then clr_errors → overrun = 0. Repeat with rd_en held high on the 5th push → no overrun.
